// File: rtl/rv32i_defs.sv
// Shared fetch-stage types for the RV32I core: FSM states, FIFO entry layout, word size.
package rv32i_defs;

    localparam int INSTR_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order skid FIFO of {pc, instr} pairs between fetch and decode.
// Flush wins over push and pop; a push into a full FIFO is only taken alongside a pop.
module fetch_fifo
    import rv32i_defs::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (do_push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (!flush_i && do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

    // Head is always registered storage, so out_* never follow imem_instr combinationally.
    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// RV32I instruction fetch: owns the PC, addresses single-cycle instruction memory,
// queues {pc, instr} toward decode, handles redirects and a sticky fetch fault.
module fetch_unit
    import rv32i_defs::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          NUM_INSTR = 32,
    parameter int          AW        = $clog2(NUM_INSTR * 4)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_instr,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic          fault,
    output logic [31:0]   fault_pc,
    output logic [0:0]    dbg_state_o
);

    localparam logic [31:0] LAST_PC    = 32'(NUM_INSTR * INSTR_BYTES - INSTR_BYTES);
    localparam logic [31:0] PC_STEP    = 32'(INSTR_BYTES);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fault_pc_q, fault_pc_d;
    logic         push;
    logic         flush;
    logic         pop;
    logic         push_ok;
    logic         pc_bad;
    logic [1:0]   count;
    fetch_entry_t push_data;
    fetch_entry_t head;

    assign pop     = out_valid && out_ready;
    assign push_ok = (count < 2'd2) || pop;
    // Range check uses the full 32-bit PC so targets beyond the memory never alias into it.
    assign pc_bad  = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);

    assign push_data.pc    = pc_q;
    assign push_data.instr = imem_instr;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        fault_pc_d = fault_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush   = 1'b1;
            pc_d    = redirect_pc;
            state_d = FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (pc_bad) begin
                        state_d    = FAULT;
                        fault_pc_d = pc_q;
                    end else if (push_ok) begin
                        push = 1'b1;
                        pc_d = pc_q + PC_STEP;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FETCH;
            pc_q       <= RESET_PC;
            fault_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_fifo u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (out_valid),
        .count_o     (count)
    );

    assign imem_addr   = pc_q[AW-1:0];
    assign out_pc      = head.pc;
    assign out_instr   = head.instr;
    assign fault       = (state_q == FAULT);
    assign fault_pc    = fault_pc_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a queue-based model.
module tb_fetch_unit;
    import rv32i_defs::*;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          NUM_INSTR = 32;
    localparam int          AW        = $clog2(NUM_INSTR * 4);
    localparam int          MEM_BYTES = NUM_INSTR * 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_instr;
    logic          redirect_valid = 1'b0;
    logic [31:0]   redirect_pc = 32'h0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_pc;
    logic [31:0]   out_instr;
    logic          fault;
    logic [31:0]   fault_pc;
    logic [0:0]    dbg_state_o;

    logic [31:0]   mem [NUM_INSTR];

    // Reference model: expected FIFO contents as {pc, instr}, plus PC and fault status.
    logic [63:0]   exp_q[$];
    logic [31:0]   m_pc;
    logic          m_fault;
    logic [31:0]   m_fault_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[AW-1:2]];

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .NUM_INSTR (NUM_INSTR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fault          (fault),
        .fault_pc       (fault_pc),
        .dbg_state_o    (dbg_state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            head = exp_q[0];
            check("out_pc", out_pc, head[63:32]);
            check("out_instr", out_instr, head[31:0]);
        end
        check("fault", 32'(fault), 32'(m_fault));
        check("fault_pc", fault_pc, m_fault_pc);
        check("imem_addr", 32'(imem_addr), m_pc % MEM_BYTES);
        check("state", 32'(dbg_state_o), m_fault ? 32'(FAULT) : 32'(FETCH));
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance the model.
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy);
        logic pop;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(negedge clk);
        check_model();
        pop = (exp_q.size() > 0) && rdy;
        if (rv) begin
            exp_q.delete();
            m_pc    = rpc;
            m_fault = 1'b0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (!m_fault) begin
                if ((m_pc % 4 != 0) || (m_pc > 32'(MEM_BYTES - 4))) begin
                    m_fault    = 1'b1;
                    m_fault_pc = m_pc;
                end else if (exp_q.size() < 2) begin
                    exp_q.push_back({m_pc, mem[int'(m_pc / 4)]});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_pc       = RESET_PC;
        m_fault    = 1'b0;
        m_fault_pc = 32'h0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        check("rst_fault_pc", fault_pc, 32'h0);
        check("rst_imem_addr", 32'(imem_addr), RESET_PC % MEM_BYTES);
        check("rst_state", 32'(dbg_state_o), 32'(FETCH));
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] tgt;
        int kind;

        for (int i = 0; i < NUM_INSTR; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0020_0113;

        // Streaming from reset with the decoder always ready.
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'h0, 1'b1);

        // Back-pressure: two entries buffered, PC stalls at 0x8, then drains in order.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
        check("stall_imem_addr", 32'(imem_addr), 32'h8);
        check("stall_head_pc", out_pc, 32'h0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1);

        // Redirect while full: flushed next cycle, target visible two cycles later.
        do_reset();
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0);
        cycle(1'b1, 32'h40, 1'b1);
        check("redir_valid_n1", 32'(out_valid), 32'h0);
        check("redir_addr_n1", 32'(imem_addr), 32'h40);
        cycle(1'b0, 32'h0, 1'b1);
        check("redir_valid_n2", 32'(out_valid), 32'h1);
        check("redir_pc_n2", out_pc, 32'h40);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);

        // Run off the end of memory, then recover with a redirect to 0.
        cycle(1'b1, 32'h70, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b1);
        check("end_fault", 32'(fault), 32'h1);
        check("end_fault_pc", fault_pc, 32'h80);
        check("end_drained", 32'(out_valid), 32'h0);
        cycle(1'b1, 32'h0, 1'b1);
        check("recover_fault", 32'(fault), 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        check("recover_pc", out_pc, 32'h0);
        check("recover_instr", out_instr, 32'h0000_0013);

        // Misaligned target faults on its own first fetch cycle.
        cycle(1'b1, 32'h06, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        check("misalign_fault", 32'(fault), 32'h1);
        check("misalign_fault_pc", fault_pc, 32'h06);
        check("misalign_no_push", 32'(out_valid), 32'h0);
        cycle(1'b0, 32'h0, 1'b1);

        // Full FIFO plus fault, then reset clears everything.
        cycle(1'b1, 32'h78, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        check("full_fault", 32'(fault), 32'h1);
        check("full_valid", 32'(out_valid), 32'h1);
        do_reset();

        // Random traffic: random back-pressure and occasional redirects of all kinds.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                kind = int'($urandom_range(0, 7));
                case (kind)
                    0:       tgt = (32'($urandom_range(0, NUM_INSTR - 1)) * 4) | 32'($urandom_range(1, 3));
                    1:       tgt = 32'(MEM_BYTES) + 32'($urandom_range(0, 63)) * 4;
                    2:       tgt = 32'hFFFF_FFFC;
                    default: tgt = 32'($urandom_range(0, NUM_INSTR - 1)) * 4;
                endcase
                cycle(1'b1, tgt, 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'b0, 32'h0, 1'($urandom_range(0, 3) != 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle-memory RV32I core. Owns the program counter and drives the byte address of the instruction memory. Captures the returned 32-bit word, which arrives combinationally in the same cycle. Buffers up to two {pc, instr} pairs in a skid FIFO toward the decoder, with a valid/ready handshake, branch/jump redirect with flush, and a sticky fetch-fault state.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `NUM_INSTR`, 32: instruction memory depth in words. Must match the memory instance.
- `AW`, $clog2(NUM_INSTR*4): memory byte-address width. Derived; not to be overridden.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_addr` out AW: byte address to instruction memory, equal to `pc[AW-1:0]`.
- `imem_instr` in 32: instruction word returned combinationally for `imem_addr`.
- `redirect_valid` in 1: taken branch/jump/trap; load `redirect_pc`.
- `redirect_pc` in 32: new PC.
- `out_valid` out 1: FIFO head valid.
- `out_ready` in 1: decoder accepts head this cycle.
- `out_pc` out 32: PC of head entry.
- `out_instr` out 32: instruction of head entry.
- `fault` out 1: sticky fetch fault.
- `fault_pc` out 32: PC that caused the fault.

## Operation
- States: FETCH, FAULT (`fetch_state_e`).
- push_ok = (count < 2) || (out_valid && out_ready).
- In FETCH with no redirect:
  - If `pc[1:0] != 0` or `pc > NUM_INSTR*4-4`, compare using the full 32-bit `pc`. Go to FAULT, set `fault_pc <= pc`, no push.
  - Else if push_ok, push {pc, imem_instr} and set `pc <= pc + 4`. This wraps modulo 2^32 with no special case.
  - Else hold `pc` (stall).
- In FAULT: no pushes, `pc` held, `fault` = 1. Entries already in the FIFO still drain normally.
- Redirect has the highest priority and applies in any state:
  - Flush the FIFO (count <= 0). This discards any pop of the same cycle; the decoder must not count on that handshake.
  - No push that cycle.
  - `pc <= redirect_pc`, state <= FETCH, `fault` cleared.
  - The new target is range/alignment-checked on its own first fetch cycle.
- Pop: when `out_valid && out_ready`, the head is removed. A simultaneous push and pop with count=2 keeps count=2.
- FIFO order is strictly in-order. `out_pc` and `out_instr` come from registered storage, never directly from `imem_instr`.

## Timing
- Reset values:
  - `pc` = RESET_PC, state = FETCH, count = 0.
  - `out_valid` = 0, `out_pc` = 0, `out_instr` = 0.
  - `fault` = 0, `fault_pc` = 0.
  - `imem_addr` = RESET_PC[AW-1:0].
- Reset applied mid-operation discards FIFO contents and fault state on that edge.
- Latency: a word addressed in cycle N is visible on `out_*` in cycle N+1 when the FIFO was empty.
- Redirect asserted in cycle N: `imem_addr` = target in N+1, and the first target instruction is valid in N+2. Bubble = 1 cycle.
- Sustained throughput: 1 instr/cycle with `out_ready` held high.
- `fault` rises the cycle after the faulting address was presented. It stays high until redirect or reset.

## Structure
- Add to `rv32i_defs`:
  - `fetch_state_e` {FETCH, FAULT}.
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]}.
  - `INSTR_BYTES` = 4.
- Sub-module `fetch_fifo`: 2-entry synchronous FIFO of `fetch_entry_t`. Ports:
  - push, push_data.
  - pop, head, valid.
  - count.
  - flush.
- Flush has priority over push/pop.
- `fetch_unit` holds the PC, FSM, fault logic and push_ok.

## Test plan
- Reset, memory words 0x00000013, 0x00100093, 0x00200113 at 0x0/0x4/0x8, `out_ready` = 1 -> cycles 1..3 after reset release show `out_pc` 0x0, 0x4, 0x8 with those instructions, `out_valid` continuously high.
- `out_ready` = 0 for 5 cycles -> count saturates at 2 and `imem_addr` holds 0x8. Release -> 0x0, 0x4, 0x8 emitted in order, none lost or duplicated.
- Redirect to 0x40 while 2 entries are buffered -> `out_valid` = 0 next cycle, `out_pc` = 0x40 two cycles after the redirect.
- NUM_INSTR = 32, sequential run -> 0x7C delivered, then `fault` = 1 with `fault_pc` = 0x80, and no further pushes. Redirect to 0x0 -> `fault` clears and 0x0 is fetched.
- Redirect to 0x06 -> `fault` = 1, `fault_pc` = 0x06, no entry pushed.
- Assert `rst` with FIFO full and `fault` set -> next cycle `out_valid` = 0, `fault` = 0, `imem_addr` = RESET_PC.
